// File: rtl/request_agent_pkg.sv
// Shared definitions for the request agent: per-unit FSM state encoding
// and the default values of the top-level parameters.
package request_agent_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_e;

  localparam int unsigned DEF_NUMUNITS     = 9;
  localparam int unsigned DEF_ADDRESSWIDTH = 3;
  localparam int unsigned DEF_PENDWIDTH    = 2;
  localparam int unsigned DEF_XFERLEN      = 4;
  localparam int unsigned DEF_AGESTEP      = 8;
  localparam int unsigned DEF_BASEPRIO     = 6;

endpackage

// File: rtl/request_agent_unit.sv
// One requesting unit: pending-job counter, IDLE/REQ/XFER FSM, request
// aging and sticky error flags. All outputs come straight from flops.
//   clock, reset      : clock, synchronous active-high reset
//   job_valid         : one-cycle pulse, adds one pending job
//   grant             : grant bit from the arbiter
//   request           : high while in REQ
//   prio              : priority field (lower = more urgent)
//   busy / done       : in XFER / last XFER cycle
//   overflow          : sticky, a job was dropped
//   grant_error       : sticky, grant seen outside REQ
module request_agent_unit
  import request_agent_pkg::*;
#(
  parameter int unsigned ADDRESSWIDTH = DEF_ADDRESSWIDTH,
  parameter int unsigned PENDWIDTH    = DEF_PENDWIDTH,
  parameter int unsigned XFERLEN      = DEF_XFERLEN,
  parameter int unsigned AGESTEP      = DEF_AGESTEP,
  parameter int unsigned BASEPRIO     = DEF_BASEPRIO
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    job_valid,
  input  logic                    grant,
  output logic                    request,
  output logic [ADDRESSWIDTH-1:0] prio,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic                    grant_error
);

  localparam logic [PENDWIDTH-1:0]    PEND_MAX  = '1;
  localparam logic [3:0]              XFER_LOAD = 4'(XFERLEN - 1);
  localparam logic [7:0]              AGE_LAST  = 8'(AGESTEP - 1);
  localparam logic [ADDRESSWIDTH-1:0] BASE      = ADDRESSWIDTH'(BASEPRIO);

  state_e                  state_q, state_d;
  logic [PENDWIDTH-1:0]    pending_q, pending_d;
  logic [3:0]              xfer_cnt_q, xfer_cnt_d;
  logic [7:0]              age_cnt_q, age_cnt_d;
  logic [ADDRESSWIDTH-1:0] prio_q, prio_d;
  logic                    request_q, request_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    overflow_q, overflow_d;
  logic                    grant_error_q, grant_error_d;
  logic                    complete;

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    xfer_cnt_d    = xfer_cnt_q;
    age_cnt_d     = age_cnt_q;
    prio_d        = prio_q;
    overflow_d    = overflow_q;
    grant_error_d = grant_error_q;

    complete = (state_q == XFER) && (xfer_cnt_q == '0);

    // A new job arriving with a completion cancels out: count unchanged.
    if (job_valid && !complete) begin
      if (pending_q == PEND_MAX) overflow_d = 1'b1;
      else                       pending_d  = pending_q + 1'b1;
    end else if (!job_valid && complete && (pending_q != '0)) begin
      pending_d = pending_q - 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (grant) grant_error_d = 1'b1;
        if (pending_q != '0) state_d = REQ;
      end
      REQ: begin
        if (grant) begin
          state_d    = XFER;
          xfer_cnt_d = XFER_LOAD;
        end else if (age_cnt_q == AGE_LAST) begin
          age_cnt_d = '0;
          if (prio_q != '0) prio_d = prio_q - 1'b1;
        end else begin
          age_cnt_d = age_cnt_q + 1'b1;
        end
      end
      XFER: begin
        if (grant) grant_error_d = 1'b1;
        if (xfer_cnt_q == '0) state_d = (pending_d != '0) ? REQ : IDLE;
        else                  xfer_cnt_d = xfer_cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Aging only survives while the unit stays in REQ; any entry into REQ
    // or any other state restarts from the base priority.
    if (!((state_q == REQ) && (state_d == REQ))) begin
      prio_d    = BASE;
      age_cnt_d = '0;
    end

    // Outputs are registered from the next state so they line up with it.
    request_d = (state_d == REQ);
    busy_d    = (state_d == XFER);
    done_d    = (state_d == XFER) && (xfer_cnt_d == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      xfer_cnt_q    <= '0;
      age_cnt_q     <= '0;
      prio_q        <= BASE;
      request_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
      grant_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      xfer_cnt_q    <= xfer_cnt_d;
      age_cnt_q     <= age_cnt_d;
      prio_q        <= prio_d;
      request_q     <= request_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      overflow_q    <= overflow_d;
      grant_error_q <= grant_error_d;
    end
  end

  assign request     = request_q;
  assign prio        = prio_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overflow    = overflow_q;
  assign grant_error = grant_error_q;

endmodule

// File: rtl/request_agent.sv
// Request agent: NUMUNITS independent request_agent_unit instances; this
// level only splits the input vectors and packs the outputs.
//   clock, reset : clock, synchronous active-high reset
//   job_valid    : [NUMUNITS] per-unit job pulses
//   grant        : [NUMUNITS] arbiter grant
//   request      : [NUMUNITS] per-unit request
//   prio         : [ADDRESSWIDTH*NUMUNITS] packed priority fields, unit i at
//                  [i*ADDRESSWIDTH +: ADDRESSWIDTH] ("priority" is a
//                  reserved word, hence the shorter name)
//   busy, done, overflow, grant_error : [NUMUNITS] per-unit status
module request_agent
  import request_agent_pkg::*;
#(
  parameter int unsigned NUMUNITS     = DEF_NUMUNITS,
  parameter int unsigned ADDRESSWIDTH = DEF_ADDRESSWIDTH,
  parameter int unsigned PENDWIDTH    = DEF_PENDWIDTH,
  parameter int unsigned XFERLEN      = DEF_XFERLEN,
  parameter int unsigned AGESTEP      = DEF_AGESTEP,
  parameter int unsigned BASEPRIO     = DEF_BASEPRIO
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUMUNITS-1:0]              job_valid,
  input  logic [NUMUNITS-1:0]              grant,
  output logic [NUMUNITS-1:0]              request,
  output logic [ADDRESSWIDTH*NUMUNITS-1:0] prio,
  output logic [NUMUNITS-1:0]              busy,
  output logic [NUMUNITS-1:0]              done,
  output logic [NUMUNITS-1:0]              overflow,
  output logic [NUMUNITS-1:0]              grant_error
);

  for (genvar i = 0; i < NUMUNITS; i++) begin : g_unit
    request_agent_unit #(
      .ADDRESSWIDTH (ADDRESSWIDTH),
      .PENDWIDTH    (PENDWIDTH),
      .XFERLEN      (XFERLEN),
      .AGESTEP      (AGESTEP),
      .BASEPRIO     (BASEPRIO)
    ) u_unit (
      .clock       (clock),
      .reset       (reset),
      .job_valid   (job_valid[i]),
      .grant       (grant[i]),
      .request     (request[i]),
      .prio        (prio[i*ADDRESSWIDTH +: ADDRESSWIDTH]),
      .busy        (busy[i]),
      .done        (done[i]),
      .overflow    (overflow[i]),
      .grant_error (grant_error[i])
    );
  end

endmodule

// File: tb/tb_request_agent.sv
module tb_request_agent;

  localparam int NU = 9;
  localparam int AW = 3;

  logic              clock;
  logic              reset;
  logic [NU-1:0]     job_valid;
  logic [NU-1:0]     grant;
  logic [NU-1:0]     request;
  logic [AW*NU-1:0]  prio;
  logic [NU-1:0]     busy;
  logic [NU-1:0]     done;
  logic [NU-1:0]     overflow;
  logic [NU-1:0]     grant_error;

  int checks   = 0;
  int failures = 0;

  request_agent #(
    .NUMUNITS     (NU),
    .ADDRESSWIDTH (AW),
    .PENDWIDTH    (2),
    .XFERLEN      (4),
    .AGESTEP      (8),
    .BASEPRIO     (6)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .job_valid   (job_valid),
    .grant       (grant),
    .request     (request),
    .prio        (prio),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .grant_error (grant_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [AW*NU-1:0] exp_prio;
    exp_prio = {NU{3'd6}};
    reset = 1'b1;
    step();
    step();
    checks++;
    if (request !== '0) begin failures++; $display("FAIL reset_request got=%b exp=0", request); end
    checks++;
    if (busy !== '0 || done !== '0) begin failures++; $display("FAIL reset_busy_done got=%b/%b exp=0/0", busy, done); end
    checks++;
    if (overflow !== '0 || grant_error !== '0) begin failures++; $display("FAIL reset_flags got=%b/%b exp=0/0", overflow, grant_error); end
    checks++;
    if (prio !== exp_prio) begin failures++; $display("FAIL reset_prio got=%h exp=%h", prio, exp_prio); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_job();
    job_valid[2] = 1'b1;               // cycle 0
    step(); job_valid[2] = 1'b0;       // cycle 1
    checks++;
    if (request[2] !== 1'b0) begin failures++; $display("FAIL single_req_c1 got=%b exp=0", request[2]); end
    step();                            // cycle 2
    checks++;
    if (request[2] !== 1'b1) begin failures++; $display("FAIL single_req_c2 got=%b exp=1", request[2]); end
    step(); step();                    // cycle 4
    checks++;
    if (request[2] !== 1'b1 || prio[6 +: 3] !== 3'd6) begin failures++; $display("FAIL single_req_c4 got=%b/%0d exp=1/6", request[2], prio[6 +: 3]); end
    grant[2] = 1'b1;
    step(); grant[2] = 1'b0;           // cycle 5
    checks++;
    if (busy[2] !== 1'b1 || request[2] !== 1'b0 || done[2] !== 1'b0) begin failures++; $display("FAIL single_xfer_c5 got=b%b r%b d%b exp=b1 r0 d0", busy[2], request[2], done[2]); end
    for (int c = 6; c <= 7; c++) begin
      step();
      checks++;
      if (busy[2] !== 1'b1 || done[2] !== 1'b0) begin failures++; $display("FAIL single_xfer_c%0d got=b%b d%b exp=b1 d0", c, busy[2], done[2]); end
    end
    step();                            // cycle 8
    checks++;
    if (busy[2] !== 1'b1 || done[2] !== 1'b1) begin failures++; $display("FAIL single_done_c8 got=b%b d%b exp=b1 d1", busy[2], done[2]); end
    step();                            // cycle 9
    checks++;
    if (busy[2] !== 1'b0 || done[2] !== 1'b0 || request[2] !== 1'b0) begin failures++; $display("FAIL single_idle_c9 got=b%b d%b r%b exp=0 0 0", busy[2], done[2], request[2]); end
  endtask

  task automatic test_aging();
    int exp_p;
    job_valid[0] = 1'b1;
    step(); job_valid[0] = 1'b0;
    step();                            // first REQ cycle, k=0
    for (int k = 0; k < 20; k++) begin
      exp_p = 6 - k / 8;
      checks++;
      if (prio[2:0] !== exp_p[2:0] || request[0] !== 1'b1) begin failures++; $display("FAIL aging_k%0d got=%0d/r%b exp=%0d/r1", k, prio[2:0], request[0], exp_p); end
      if (k < 19) step();
    end
    grant[0] = 1'b1;
    step(); grant[0] = 1'b0;
    checks++;
    if (prio[2:0] !== 3'd6 || busy[0] !== 1'b1) begin failures++; $display("FAIL aging_granted got=%0d/b%b exp=6/b1", prio[2:0], busy[0]); end
    repeat (4) step();
    checks++;
    if (busy[0] !== 1'b0 || request[0] !== 1'b0) begin failures++; $display("FAIL aging_end got=b%b r%b exp=0 0", busy[0], request[0]); end
  endtask

  // Unit 1 gets four jobs (one dropped), unit 4 gets three (none dropped);
  // both then see a new job coincident with their done pulse.
  task automatic test_overflow();
    job_valid[1] = 1'b1; job_valid[4] = 1'b1;   // cycles 0..2
    step(); step(); step();
    job_valid[4] = 1'b0;                        // cycle 3
    checks++;
    if (overflow[1] !== 1'b0) begin failures++; $display("FAIL ovf_before got=%b exp=0", overflow[1]); end
    step(); job_valid[1] = 1'b0;                // cycle 4
    checks++;
    if (overflow[1] !== 1'b1 || overflow[4] !== 1'b0) begin failures++; $display("FAIL ovf_set got=%b%b exp=10", overflow[1], overflow[4]); end
    grant[1] = 1'b1; grant[4] = 1'b1;
    step(); grant[1] = 1'b0; grant[4] = 1'b0;   // cycle 5
    step(); step(); step();                     // cycle 8
    checks++;
    if (done[1] !== 1'b1 || done[4] !== 1'b1) begin failures++; $display("FAIL ovf_done got=%b%b exp=11", done[1], done[4]); end
    job_valid[1] = 1'b1; job_valid[4] = 1'b1;
    step(); job_valid[1] = 1'b0; job_valid[4] = 1'b0;   // cycle 9
    checks++;
    if (overflow[1] !== 1'b1 || overflow[4] !== 1'b0) begin failures++; $display("FAIL ovf_coincident got=%b%b exp=10", overflow[1], overflow[4]); end
    // Three jobs must still be pending in each unit.
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (request[1] !== 1'b1 || request[4] !== 1'b1) begin failures++; $display("FAIL ovf_drain_req%0d got=%b%b exp=11", j, request[1], request[4]); end
      grant[1] = 1'b1; grant[4] = 1'b1;
      step(); grant[1] = 1'b0; grant[4] = 1'b0;
      step(); step(); step();
      checks++;
      if (done[1] !== 1'b1 || done[4] !== 1'b1) begin failures++; $display("FAIL ovf_drain_done%0d got=%b%b exp=11", j, done[1], done[4]); end
      step();
    end
    checks++;
    if (request[1] !== 1'b0 || request[4] !== 1'b0 || grant_error[1] !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%b%b ge%b exp=00 ge0", request[1], request[4], grant_error[1]); end
  endtask

  task automatic test_back_to_back();
    job_valid[6] = 1'b1;                // cycles 0,1
    step(); step(); job_valid[6] = 1'b0; // cycle 2
    checks++;
    if (request[6] !== 1'b1) begin failures++; $display("FAIL b2b_req got=%b exp=1", request[6]); end
    grant[6] = 1'b1;                    // held through cycle 3 (in XFER)
    step();                             // cycle 3
    checks++;
    if (busy[6] !== 1'b1 || grant_error[6] !== 1'b0) begin failures++; $display("FAIL b2b_xfer got=b%b ge%b exp=b1 ge0", busy[6], grant_error[6]); end
    step(); grant[6] = 1'b0;            // cycle 4
    checks++;
    if (grant_error[6] !== 1'b1 || busy[6] !== 1'b1) begin failures++; $display("FAIL b2b_xfer_grant got=ge%b b%b exp=ge1 b1", grant_error[6], busy[6]); end
    step(); step();                     // cycle 6
    checks++;
    if (done[6] !== 1'b1) begin failures++; $display("FAIL b2b_done1 got=%b exp=1", done[6]); end
    step();                             // cycle 7
    checks++;
    if (request[6] !== 1'b1 || busy[6] !== 1'b0 || done[6] !== 1'b0) begin failures++; $display("FAIL b2b_rereq got=r%b b%b d%b exp=r1 b0 d0", request[6], busy[6], done[6]); end
    grant[6] = 1'b1;
    step(); grant[6] = 1'b0;            // cycle 8
    step(); step(); step();             // cycle 11
    checks++;
    if (done[6] !== 1'b1) begin failures++; $display("FAIL b2b_done2 got=%b exp=1", done[6]); end
    step();                             // cycle 12
    checks++;
    if (request[6] !== 1'b0 || busy[6] !== 1'b0) begin failures++; $display("FAIL b2b_idle got=r%b b%b exp=0 0", request[6], busy[6]); end
  endtask

  task automatic test_stray_grant();
    grant[5] = 1'b1;
    step(); grant[5] = 1'b0;
    checks++;
    if (grant_error[5] !== 1'b1 || request[5] !== 1'b0) begin failures++; $display("FAIL stray_set got=ge%b r%b exp=ge1 r0", grant_error[5], request[5]); end
    step(); step(); step();
    checks++;
    if (grant_error[5] !== 1'b1 || request[5] !== 1'b0 || busy[5] !== 1'b0) begin failures++; $display("FAIL stray_sticky got=ge%b r%b b%b exp=ge1 r0 b0", grant_error[5], request[5], busy[5]); end
  endtask

  task automatic test_reset_mid_xfer();
    job_valid[3] = 1'b1;                // two jobs: cycles 0,1
    step(); step(); job_valid[3] = 1'b0; // cycle 2
    checks++;
    if (request[3] !== 1'b1) begin failures++; $display("FAIL rst_req got=%b exp=1", request[3]); end
    grant[3] = 1'b1;
    step(); grant[3] = 1'b0;            // cycle 3, XFER cycle 1
    step();                             // cycle 4, XFER cycle 2
    checks++;
    if (busy[3] !== 1'b1) begin failures++; $display("FAIL rst_busy_before got=%b exp=1", busy[3]); end
    reset = 1'b1;
    step(); reset = 1'b0;               // cycle 5
    checks++;
    if (busy[3] !== 1'b0 || done[3] !== 1'b0 || prio[9 +: 3] !== 3'd6) begin failures++; $display("FAIL rst_abort got=b%b d%b p%0d exp=b0 d0 p6", busy[3], done[3], prio[9 +: 3]); end
    checks++;
    if (grant_error !== '0 || overflow !== '0) begin failures++; $display("FAIL rst_flags got=%b/%b exp=0/0", grant_error, overflow); end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (request[3] !== 1'b0 || done[3] !== 1'b0 || busy[3] !== 1'b0) begin failures++; $display("FAIL rst_discard_c%0d got=r%b d%b b%b exp=0 0 0", c, request[3], done[3], busy[3]); end
      step();
    end
  endtask

  initial begin
    reset     = 1'b1;
    job_valid = '0;
    grant     = '0;
    test_reset();
    test_single_job();
    test_aging();
    test_overflow();
    test_back_to_back();
    test_stray_grant();
    test_reset_mid_xfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/request_agent.md
REQUEST_AGENT -- requirements
Module: request_agent

Interface
REQ-001 Parameter NUMUNITS, default 9, number of requesting units (one bit per unit on every unit vector).
REQ-002 Parameter ADDRESSWIDTH, default 3, width of each per-unit priority field.
REQ-003 Parameter PENDWIDTH, default 2, width of each per-unit pending-job counter (max 3 jobs).
REQ-004 Parameter XFERLEN, default 4, cycles a unit holds the resource per grant; legal range 1..16.
REQ-005 Parameter AGESTEP, default 8, waiting cycles per one-step priority increase; legal range 1..255.
REQ-006 Parameter BASEPRIO, default 6, priority value of a unit that is not waiting; lower value = more urgent.
REQ-007 clock  input  1  sole clock; all state updates on rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 job_valid  input  NUMUNITS  one-cycle pulse per bit; adds one pending job to that unit.
REQ-010 grant  input  NUMUNITS  registered one-hot grant from the arbiter.
REQ-011 request  output  NUMUNITS  per-unit request to the arbiter.
REQ-012 priority  output  ADDRESSWIDTH*NUMUNITS  packed per-unit priority; unit i occupies bits [i*ADDRESSWIDTH +: ADDRESSWIDTH].
REQ-013 busy  output  NUMUNITS  unit is in XFER.
REQ-014 done  output  NUMUNITS  one-cycle pulse on the last XFER cycle.
REQ-015 overflow  output  NUMUNITS  sticky flag: a job was dropped.
REQ-016 grant_error  output  NUMUNITS  sticky flag: grant received while not in REQ.

Function
REQ-017 Each unit SHALL run an independent FSM with states IDLE, REQ and XFER.
REQ-018 IDLE SHALL go to REQ on the next edge when pending > 0.
REQ-019 request[i] SHALL be 1 exactly while unit i is in REQ.
REQ-020 In REQ, grant[i]=1 SHALL move the unit to XFER and load xfer_cnt with XFERLEN-1.
REQ-021 In XFER, busy[i]=1, and xfer_cnt SHALL decrement each cycle.
REQ-022 In XFER with xfer_cnt=0: done[i] pulses, pending decrements, next state is REQ if the post-update pending > 0, else IDLE.
REQ-023 A job_valid pulse while pending is at its maximum SHALL be dropped and SHALL set overflow[i], unless the same cycle completes a job.
REQ-024 A job_valid pulse in the same cycle as a completion SHALL leave pending unchanged and SHALL NOT flag overflow.
REQ-025 Pending arithmetic SHALL be unsigned and SHALL never wrap below 0 or above 2^PENDWIDTH-1.
REQ-026 In REQ, age_cnt SHALL count cycles. On reaching AGESTEP-1 it SHALL clear, and the unit's priority field SHALL decrement, saturating at 0.
REQ-027 On entering REQ, and in IDLE and XFER, the priority field SHALL equal BASEPRIO and age_cnt SHALL equal 0.
REQ-028 grant[i]=1 in IDLE or XFER SHALL be ignored for state purposes and SHALL set grant_error[i].
REQ-029 A grant with more than one bit set SHALL be handled per unit, with no cross-unit checking.
REQ-030 All outputs SHALL be registered. request SHALL deassert in the cycle after the grant is sampled.

Reset
REQ-031 While reset=1, on a rising edge, every unit SHALL enter IDLE, and pending, xfer_cnt and age_cnt SHALL clear.
REQ-032 Reset output values: request=0, busy=0, done=0, overflow=0, grant_error=0, and every priority field = BASEPRIO.
REQ-033 Reset asserted mid-XFER SHALL abort the transfer with no done pulse; jobs pending at that point are discarded.

Structure
REQ-034 A shared package SHALL hold the FSM state enumeration (IDLE, REQ, XFER) and the default parameter constants.
REQ-035 Per-unit logic SHALL be a sub-module request_agent_unit, instantiated NUMUNITS times by request_agent, which only packs and unpacks the vectors.

Verification
REQ-036 Single job: job_valid[2] at cycle 0 -> request[2]=1 from cycle 2; grant[2] at cycle 4 -> busy[2]=1 for cycles 5-8; done[2] at cycle 8; request[2]=0 from cycle 5.
REQ-037 Aging: unit 0 in REQ for 20 cycles with no grant, AGESTEP=8 -> priority[2:0] goes 6 -> 5 after 8 cycles, then 5 -> 4 after 16 cycles; back to 6 on grant.
REQ-038 Overflow: four job_valid[1] pulses with no grant -> pending=3, overflow[1]=1; a later job_valid coincident with done[1] -> overflow unchanged, pending stays 3.
REQ-039 Back-to-back jobs: pending=2, grant in REQ -> after the done pulse the unit returns to REQ (request=1 on the next cycle), not IDLE.
REQ-040 Stray grant: grant[5]=1 while unit 5 is IDLE -> grant_error[5]=1 (sticky), state stays IDLE, request[5]=0.
REQ-041 Reset mid-operation: reset=1 during unit 3 XFER cycle 2 -> next cycle busy[3]=0, done[3]=0, priority field = 6, pending = 0.
